// File: rtl/arcade_input_pkg.sv
// Shared constants, lives DIP encodings, mode FSM state type and the
// player bit-order helper for the arcade input mux.
package arcade_input_pkg;

  localparam logic [1:0] GAME_BLOCKADE = 2'd0;
  localparam logic [1:0] GAME_COMOTION = 2'd1;

  // Cabinet ports are active-low, so "nothing pressed" is all ones.
  localparam logic [7:0] PORT_IDLE = 8'hFF;

  // Blockade lives DIP settings (raw switch bits).
  localparam logic [2:0] LIVES_BLK_6 = 3'b000;
  localparam logic [2:0] LIVES_BLK_5 = 3'b100;
  localparam logic [2:0] LIVES_BLK_4 = 3'b110;
  localparam logic [2:0] LIVES_BLK_3 = 3'b011;

  // Comotion only looks at bit 0 of the lives DIP.
  localparam logic LIVES_COM_4 = 1'b0;
  localparam logic LIVES_COM_3 = 1'b1;

  typedef enum logic {
    MODE_RUN   = 1'b0,
    MODE_GUARD = 1'b1
  } mode_state_t;

  // Reorder one joystick group from the host order {up,down,left,right}
  // into the cabinet order {left,down,right,up}.
  function automatic logic [3:0] player_bits(input logic [3:0] j);
    return {j[1], j[2], j[0], j[3]};
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Single-bit debouncer: the accepted value only flips after the raw input
// has disagreed with it for 2^DB_BITS-1 consecutive ce ticks.
module input_debounce
  import arcade_input_pkg::*;
#(
  parameter int DB_BITS = 3
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ce,
  input  logic din,
  output logic dout
);

  // The flip happens on the tick that would take the counter to all ones.
  localparam int              CNT_LAST_I = (1 << DB_BITS) - 2;
  localparam logic [DB_BITS-1:0] CNT_LAST = CNT_LAST_I[DB_BITS-1:0];

  logic [DB_BITS-1:0] cnt_reg;
  logic               dout_reg;

  // Count consecutive disagreeing ticks; any agreeing tick starts over.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_reg  <= '0;
      dout_reg <= 1'b0;
    end else if (ce) begin
      if (din != dout_reg) begin
        if (cnt_reg == CNT_LAST) begin
          dout_reg <= din;
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/arcade_input_mux.sv
// Debounces player controls, stretches the coin button and maps controls
// and DIPs onto the active-low cabinet ports for the selected game. A mode
// change idles every port for a guard interval before the new map applies.
module arcade_input_mux
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int DB_BITS     = 3,
  parameter int COIN_LEN    = 16,
  parameter int GUARD_LEN   = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ce,
  input  logic [1:0]               game_mode,
  input  logic [NUM_PLAYERS*4-1:0] joy,
  input  logic                     btn_coin,
  input  logic                     btn_start,
  input  logic                     btn_boom,
  input  logic [2:0]               dip_lives,
  output logic [7:0]               in_1,
  output logic [7:0]               in_2,
  output logic [7:0]               in_4,
  output logic                     coin,
  output logic [1:0]               mode_active,
  output logic                     mode_busy
);

  localparam int         NUM_JOY    = NUM_PLAYERS * 4;
  localparam int         NUM_RAW    = NUM_JOY + 3;
  localparam logic [7:0] COIN_LOAD  = 8'(COIN_LEN);
  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_LEN);

  logic [NUM_RAW-1:0] raw_bus;
  logic [NUM_RAW-1:0] db_bus;
  logic [NUM_JOY-1:0] joy_db;
  logic               coin_db, start_db, boom_db;
  logic [3:0]         p1, p2, p3, p4;

  assign raw_bus = {btn_boom, btn_start, btn_coin, joy};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RAW; gi++) begin : g_db
      input_debounce #(.DB_BITS(DB_BITS)) u_db (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce      (ce),
        .din     (raw_bus[gi]),
        .dout    (db_bus[gi])
      );
    end
  endgenerate

  assign joy_db   = db_bus[NUM_JOY-1:0];
  assign coin_db  = db_bus[NUM_JOY];
  assign start_db = db_bus[NUM_JOY+1];
  assign boom_db  = db_bus[NUM_JOY+2];

  assign p1 = player_bits(joy_db[3:0]);
  assign p2 = player_bits(joy_db[7:4]);

  // A two-player build reuses P1/P2 for the P3/P4 slots.
  generate
    if (NUM_PLAYERS == 4) begin : g_four
      assign p3 = player_bits(joy_db[11:8]);
      assign p4 = player_bits(joy_db[15:12]);
    end else begin : g_two
      assign p3 = p1;
      assign p4 = p2;
    end
  endgenerate

  // Coin pulse: start on a debounced rising edge while idle, run COIN_LEN ticks.
  logic       coin_reg, coin_prev_reg;
  logic [7:0] coin_cnt_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      coin_reg      <= 1'b0;
      coin_prev_reg <= 1'b0;
      coin_cnt_reg  <= 8'd0;
    end else begin
      coin_prev_reg <= coin_db;
      if (!coin_reg) begin
        if (coin_db && !coin_prev_reg) begin
          coin_reg     <= 1'b1;
          coin_cnt_reg <= COIN_LOAD;
        end
      end else if (ce) begin
        if (coin_cnt_reg <= 8'd1) begin
          coin_reg     <= 1'b0;
          coin_cnt_reg <= 8'd0;
        end else begin
          coin_cnt_reg <= coin_cnt_reg - 8'd1;
        end
      end
    end
  end

  assign coin = coin_reg;

  // Mode FSM and port registers.
  mode_state_t state_reg, state_next;
  logic [1:0]  mode_reg, mode_next;
  logic [7:0]  guard_cnt_reg, guard_cnt_next;
  logic        busy_reg, busy_next;
  logic [7:0]  in_1_reg, in_1_next;
  logic [7:0]  in_2_reg, in_2_next;
  logic [7:0]  in_4_reg, in_4_next;

  // State, mode and port registers; reset reloads the mode from game_mode.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg     <= MODE_RUN;
      mode_reg      <= game_mode;
      guard_cnt_reg <= 8'd0;
      busy_reg      <= 1'b0;
      in_1_reg      <= PORT_IDLE;
      in_2_reg      <= PORT_IDLE;
      in_4_reg      <= PORT_IDLE;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      guard_cnt_reg <= guard_cnt_next;
      busy_reg      <= busy_next;
      in_1_reg      <= in_1_next;
      in_2_reg      <= in_2_next;
      in_4_reg      <= in_4_next;
    end
  end

  // Next-state logic, then the port map built from the next state/mode so
  // the ports go idle on the same edge the guard starts and map on exit.
  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    guard_cnt_next = guard_cnt_reg;
    busy_next      = busy_reg;
    in_1_next      = PORT_IDLE;
    in_2_next      = PORT_IDLE;
    in_4_next      = PORT_IDLE;

    case (state_reg)
      MODE_RUN: begin
        if (game_mode != mode_reg) begin
          state_next     = MODE_GUARD;
          busy_next      = 1'b1;
          guard_cnt_next = GUARD_LOAD;
        end
      end
      MODE_GUARD: begin
        // Later game_mode changes are ignored until the count expires.
        if (ce) begin
          if (guard_cnt_reg <= 8'd1) begin
            state_next     = MODE_RUN;
            busy_next      = 1'b0;
            mode_next      = game_mode;
            guard_cnt_next = 8'd0;
          end else begin
            guard_cnt_next = guard_cnt_reg - 8'd1;
          end
        end
      end
      default: begin
        state_next = MODE_RUN;
        busy_next  = 1'b0;
      end
    endcase

    if (state_next == MODE_RUN) begin
      case (mode_next)
        GAME_BLOCKADE: begin
          in_1_next = ~{1'b0, dip_lives, 1'b0, boom_db, 2'b00};
          in_2_next = ~{p2, p1};
        end
        GAME_COMOTION: begin
          in_1_next = ~{p4, p3};
          in_2_next = ~{3'b000, start_db, dip_lives[0], boom_db, 2'b00};
          in_4_next = ~{p2, p1};
        end
        default: begin
          in_1_next = PORT_IDLE;
        end
      endcase
    end
  end

  assign in_1        = in_1_reg;
  assign in_2        = in_2_reg;
  assign in_4        = in_4_reg;
  assign mode_active = mode_reg;
  assign mode_busy   = busy_reg;

endmodule

// File: tb/tb_arcade_input_mux.sv
// Directed bench for arcade_input_mux: a 4-player and a 2-player instance
// share all stimulus; expected port values are worked out by hand.
module tb_arcade_input_mux;
  import arcade_input_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce;
  logic [1:0]  game_mode;
  logic [15:0] joy;
  logic        btn_coin, btn_start, btn_boom;
  logic [2:0]  dip_lives;

  logic [7:0] in_1_a, in_2_a, in_4_a, in_1_b, in_2_b, in_4_b;
  logic       coin_a, coin_b, busy_a, busy_b;
  logic [1:0] mode_a, mode_b;

  int tests_run    = 0;
  int tests_failed = 0;

  arcade_input_mux #(.NUM_PLAYERS(4), .DB_BITS(3), .COIN_LEN(16), .GUARD_LEN(8)) dut4 (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .game_mode(game_mode), .joy(joy),
    .btn_coin(btn_coin), .btn_start(btn_start), .btn_boom(btn_boom), .dip_lives(dip_lives),
    .in_1(in_1_a), .in_2(in_2_a), .in_4(in_4_a), .coin(coin_a),
    .mode_active(mode_a), .mode_busy(busy_a)
  );

  arcade_input_mux #(.NUM_PLAYERS(2), .DB_BITS(3), .COIN_LEN(16), .GUARD_LEN(8)) dut2 (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .game_mode(game_mode), .joy(joy[7:0]),
    .btn_coin(btn_coin), .btn_start(btn_start), .btn_boom(btn_boom), .dip_lives(dip_lives),
    .in_1(in_1_b), .in_2(in_2_b), .in_4(in_4_b), .coin(coin_b),
    .mode_active(mode_b), .mode_busy(busy_b)
  );

  always #5 clk_sys = ~clk_sys;

  // Advance n clocks; outputs are read 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; game_mode = 2'd1;
    step(2);
    tests_run++;
    if (mode_a !== 2'd1) begin tests_failed++; $display("FAIL reset_mode_load got %0d expected 1", mode_a); end
    tests_run++;
    if (in_1_a !== 8'hFF || in_2_a !== 8'hFF || in_4_a !== 8'hFF) begin
      tests_failed++; $display("FAIL reset_ports got %h %h %h expected ff ff ff", in_1_a, in_2_a, in_4_a);
    end
    tests_run++;
    if (coin_a !== 1'b0 || busy_a !== 1'b0) begin
      tests_failed++; $display("FAIL reset_coin_busy got %b %b expected 0 0", coin_a, busy_a);
    end
    game_mode = 2'd0;
    step(1);
    tests_run++;
    if (mode_a !== 2'd0) begin tests_failed++; $display("FAIL reset_mode_reload got %0d expected 0", mode_a); end
    reset = 1'b0;
    step(1);
    $display("[TB] test_reset done");
  endtask

  // P1 right held: port changes after the 8th edge (7 ticks + register).
  task automatic test_debounce();
    joy[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (k == 7) begin
        tests_run++;
        if (in_2_a !== 8'hFF) begin tests_failed++; $display("FAIL db_early got %h expected ff", in_2_a); end
      end
      if (k == 8) begin
        tests_run++;
        if (in_2_a !== 8'hFD) begin tests_failed++; $display("FAIL db_in_2 got %h expected fd", in_2_a); end
        tests_run++;
        if (in_2_b !== 8'hFD) begin tests_failed++; $display("FAIL db_in_2_two got %h expected fd", in_2_b); end
      end
    end
    // dip 100 lands in bits 6:4, boom released: ~8'h40
    tests_run++;
    if (in_1_a !== 8'hBF) begin tests_failed++; $display("FAIL db_in_1 got %h expected bf", in_1_a); end
    tests_run++;
    if (in_4_a !== 8'hFF) begin tests_failed++; $display("FAIL db_in_4 got %h expected ff", in_4_a); end
    $display("[TB] test_debounce done");
  endtask

  task automatic test_glitch();
    joy[7] = 1'b1; step(3); joy[7] = 1'b0; step(10);
    tests_run++;
    if (in_2_a !== 8'hFD) begin tests_failed++; $display("FAIL glitch3 got %h expected fd", in_2_a); end
    joy[7] = 1'b1; step(6); joy[7] = 1'b0; step(10);
    tests_run++;
    if (in_2_a !== 8'hFD) begin tests_failed++; $display("FAIL glitch6 got %h expected fd", in_2_a); end
    // Seven ticks is exactly the threshold: P2 up gets through.
    joy[7] = 1'b1; step(7); joy[7] = 1'b0; step(1);
    tests_run++;
    if (in_2_a !== 8'hED) begin tests_failed++; $display("FAIL glitch7 got %h expected ed", in_2_a); end
    step(10);
    tests_run++;
    if (in_2_a !== 8'hFD) begin tests_failed++; $display("FAIL glitch7_release got %h expected fd", in_2_a); end
    joy = 16'h0000;
    step(8);
    tests_run++;
    if (in_2_a !== 8'hFF) begin tests_failed++; $display("FAIL joy_release got %h expected ff", in_2_a); end
    $display("[TB] test_glitch done");
  endtask

  // Press, release, press again while the pulse is still running.
  task automatic test_coin();
    int high_cnt = 0;
    int rise_cnt = 0;
    int first_k  = 0;
    logic prev   = 1'b0;
    for (int k = 1; k <= 75; k++) begin
      btn_coin = (k <= 8) || (k >= 16 && k <= 60);
      step(1);
      if (coin_a) begin
        high_cnt++;
        if (first_k == 0) first_k = k;
      end
      if (coin_a && !prev) rise_cnt++;
      prev = coin_a;
    end
    btn_coin = 1'b0;
    tests_run++;
    if (high_cnt != 16) begin tests_failed++; $display("FAIL coin_len got %0d expected 16", high_cnt); end
    tests_run++;
    if (rise_cnt != 1) begin tests_failed++; $display("FAIL coin_pulses got %0d expected 1", rise_cnt); end
    tests_run++;
    if (first_k != 8) begin tests_failed++; $display("FAIL coin_start got %0d expected 8", first_k); end
    $display("[TB] test_coin done");
  endtask

  task automatic test_mode_switch();
    joy = 16'h0008;                 // P1 up
    dip_lives = {2'b00, LIVES_COM_3};
    step(8);
    tests_run++;
    if (in_2_a !== 8'hFE) begin tests_failed++; $display("FAIL pre_switch_in_2 got %h expected fe", in_2_a); end
    game_mode = GAME_COMOTION;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) game_mode = 2'd3;
      if (k == 6) game_mode = GAME_COMOTION;
      step(1);
      tests_run++;
      if (busy_a !== 1'b1 || mode_a !== 2'd0) begin
        tests_failed++; $display("FAIL guard_busy k=%0d got busy=%b mode=%0d expected 1 0", k, busy_a, mode_a);
      end
      tests_run++;
      if (in_1_a !== 8'hFF || in_2_a !== 8'hFF || in_4_a !== 8'hFF) begin
        tests_failed++; $display("FAIL guard_ports k=%0d got %h %h %h expected ff ff ff", k, in_1_a, in_2_a, in_4_a);
      end
    end
    step(1);
    tests_run++;
    if (busy_a !== 1'b0 || mode_a !== 2'd1) begin
      tests_failed++; $display("FAIL guard_exit got busy=%b mode=%0d expected 0 1", busy_a, mode_a);
    end
    tests_run++;
    if (in_4_a !== 8'hFE) begin tests_failed++; $display("FAIL com_in_4 got %h expected fe", in_4_a); end
    tests_run++;
    if (in_2_a !== 8'hF7) begin tests_failed++; $display("FAIL com_in_2 got %h expected f7", in_2_a); end
    tests_run++;
    if (in_1_a !== 8'hFF) begin tests_failed++; $display("FAIL com_in_1 got %h expected ff", in_1_a); end
    $display("[TB] test_mode_switch done");
  endtask

  task automatic test_mirror();
    joy = 16'h0002;                 // P1 left
    step(8);
    tests_run++;
    if (in_1_b !== 8'hF7 || in_4_b !== 8'hF7) begin
      tests_failed++; $display("FAIL mirror_two got %h %h expected f7 f7", in_1_b, in_4_b);
    end
    tests_run++;
    if (in_1_a !== 8'hFF || in_4_a !== 8'hF7) begin
      tests_failed++; $display("FAIL mirror_four got %h %h expected ff f7", in_1_a, in_4_a);
    end
    btn_start = 1'b1; btn_boom = 1'b1;
    step(8);
    tests_run++;
    if (in_2_a !== 8'hE3) begin tests_failed++; $display("FAIL com_buttons got %h expected e3", in_2_a); end
    btn_start = 1'b0; btn_boom = 1'b0;
    step(8);
    $display("[TB] test_mirror done");
  endtask

  task automatic test_reserved();
    game_mode = 2'd2;
    step(9);
    tests_run++;
    if (busy_a !== 1'b0 || mode_a !== 2'd2) begin
      tests_failed++; $display("FAIL reserved_mode got busy=%b mode=%0d expected 0 2", busy_a, mode_a);
    end
    tests_run++;
    if (in_4_a !== 8'hFF || in_1_b !== 8'hFF) begin
      tests_failed++; $display("FAIL reserved_ports got %h %h expected ff ff", in_4_a, in_1_b);
    end
    $display("[TB] test_reserved done");
  endtask

  task automatic test_reset_mid();
    game_mode = GAME_BLOCKADE;
    step(9);
    btn_coin = 1'b1;
    step(10);
    game_mode = GAME_COMOTION;
    step(3);
    tests_run++;
    if (coin_a !== 1'b1 || busy_a !== 1'b1) begin
      tests_failed++; $display("FAIL mid_setup got coin=%b busy=%b expected 1 1", coin_a, busy_a);
    end
    reset = 1'b1; btn_coin = 1'b0;
    step(1);
    tests_run++;
    if (in_1_a !== 8'hFF || in_2_a !== 8'hFF || in_4_a !== 8'hFF) begin
      tests_failed++; $display("FAIL mid_reset_ports got %h %h %h expected ff ff ff", in_1_a, in_2_a, in_4_a);
    end
    tests_run++;
    if (coin_a !== 1'b0 || busy_a !== 1'b0 || mode_a !== 2'd1) begin
      tests_failed++; $display("FAIL mid_reset_state got coin=%b busy=%b mode=%0d expected 0 0 1", coin_a, busy_a, mode_a);
    end
    reset = 1'b0;
    step(1);
    tests_run++;
    if (coin_a !== 1'b0 || busy_a !== 1'b0 || in_4_a !== 8'hFF) begin
      tests_failed++; $display("FAIL post_reset got coin=%b busy=%b in_4=%h expected 0 0 ff", coin_a, busy_a, in_4_a);
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; game_mode = 2'd0; joy = 16'h0000;
    btn_coin = 1'b0; btn_start = 1'b0; btn_boom = 1'b0; dip_lives = LIVES_BLK_5;
    test_reset();
    test_debounce();
    test_glitch();
    test_coin();
    test_mode_switch();
    test_mirror();
    test_reserved();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
